// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced, clock-synchronous button level into
//               single-cycle user-intent pulses: press, release, short press,
//               long press, auto-repeat while held and double click.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DOUBLE_CYC = 12_500_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic busy
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_PRESSED1  = 3'd1;
    localparam logic [2:0] c_ST_LONG_HELD = 3'd2;
    localparam logic [2:0] c_ST_WAIT2     = 3'd3;
    localparam logic [2:0] c_ST_PRESSED2  = 3'd4;

    // Terminal counts: the counter starts at 0 the edge a state is entered,
    // so the last count value of an N-cycle interval is N-1.
    localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_DOUBLE_LAST = CNT_W'(DOUBLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    logic             r_level_q;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             r_double;

    logic             w_rise;
    logic             w_fall;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_release;
    logic             w_short;
    logic             w_long;
    logic             w_repeat;
    logic             w_double;

    assign w_rise = level & ~r_level_q;
    assign w_fall = ~level & r_level_q;

    // Next-state, counter and event decode for one clock edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_double    = 1'b0;

        if (!en) begin
            // Disabled: drop whatever was in flight without emitting anything
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = c_CNT_ZERO;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_cnt_nxt = c_CNT_ZERO;
                    // A fall here (e.g. button held through reset) is ignored
                    if (w_rise) begin
                        w_state_nxt = c_ST_PRESSED1;
                        w_press     = 1'b1;
                    end
                end
                c_ST_PRESSED1: begin
                    // Fall wins over long expiry on the same edge: short press
                    if (w_fall) begin
                        w_state_nxt = c_ST_WAIT2;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_release   = 1'b1;
                    end else if (r_cnt == c_LONG_LAST) begin
                        w_state_nxt = c_ST_LONG_HELD;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_long      = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_LONG_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_release   = 1'b1;
                    end else if (r_cnt == c_REPEAT_LAST) begin
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_repeat    = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_WAIT2: begin
                    // A second press wins over window expiry on the same edge
                    if (w_rise) begin
                        w_state_nxt = c_ST_PRESSED2;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_press     = 1'b1;
                        w_double    = 1'b1;
                    end else if (r_cnt == c_DOUBLE_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_short     = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_PRESSED2: begin
                    // No long/repeat tracking on the second press of a double
                    w_cnt_nxt = c_CNT_ZERO;
                    if (w_fall) begin
                        w_state_nxt = c_ST_IDLE;
                        w_release   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            endcase
        end
    end

    // Level history: resets high so a button held through reset is not a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b1;
        end else begin
            r_level_q <= level;
        end
    end

    // State, counter and registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= c_CNT_ZERO;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_double  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_short   <= w_short;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_double  <= w_double;
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_press   = r_short;
    assign long_press    = r_long;
    assign repeat_pulse  = r_repeat;
    assign double_click  = r_double;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Self-checking bench for button_event_decoder: directed
//               scenarios plus randomized level/enable/reset stimulus against
//               a timestamp-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int c_L = 8;
    localparam int c_D = 5;
    localparam int c_R = 3;
    localparam int c_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;
    logic level = 1'b0;
    logic press_pulse, release_pulse, short_press, long_press;
    logic repeat_pulse, double_click, busy;
    logic [6:0] outs;

    button_event_decoder #(
        .LONG_CYC   (c_L),
        .DOUBLE_CYC (c_D),
        .REPEAT_CYC (c_R),
        .CNT_W      (c_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .double_click  (double_click),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    assign outs = {press_pulse, release_pulse, short_press, long_press,
                   repeat_pulse, double_click, busy};

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    // Comparison helper: every check in the bench goes through here
    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_no, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the user's gesture as a phase plus the edge at which it began;
    // pulse timing is derived arithmetically from elapsed edges.
    localparam int P_NONE = 0, P_HOLD1 = 1, P_GAP = 2, P_HOLD2 = 3;
    int   m_phase = P_NONE;
    int   m_t     = 0;
    logic m_prev  = 1'b1;
    logic [31:0] m_exp = '0;

    task automatic model_reset();
        m_phase = P_NONE;
        m_prev  = 1'b1;
        m_exp   = '0;
    endtask

    task automatic model_edge(input logic lvl, input logic en_v);
        logic rise, fall;
        logic p, r, s, lg, rp, db;
        int d;
        rise = lvl & ~m_prev;
        fall = ~lvl & m_prev;
        {p, r, s, lg, rp, db} = 6'b0;
        if (!en_v) begin
            m_phase = P_NONE;
        end else if (m_phase == P_NONE) begin
            if (rise) begin p = 1'b1; m_phase = P_HOLD1; m_t = edge_no; end
        end else if (m_phase == P_HOLD1) begin
            d = edge_no - m_t;
            if (fall) begin
                r = 1'b1;
                // released at or before the long threshold -> still a short press
                m_phase = (d > c_L) ? P_NONE : P_GAP;
                m_t = edge_no;
            end else if (d == c_L) begin
                lg = 1'b1;
            end else if (d > c_L && ((d - c_L) % c_R) == 0) begin
                rp = 1'b1;
            end
        end else if (m_phase == P_GAP) begin
            if (rise) begin
                p = 1'b1; db = 1'b1; m_phase = P_HOLD2;
            end else if (edge_no - m_t == c_D) begin
                s = 1'b1; m_phase = P_NONE;
            end
        end else begin
            if (fall) begin r = 1'b1; m_phase = P_NONE; end
        end
        m_prev = lvl;
        m_exp  = {25'b0, p, r, s, lg, rp, db, (m_phase != P_NONE)};
    endtask

    // ---------------- scenario bookkeeping ----------------
    int base_edge;
    int f_press, f_short, f_long, f_dbl, l_rel, n_rep, n_press, n_rel;

    task automatic clear_stats();
        base_edge = edge_no;
        f_press = 0; f_short = 0; f_long = 0; f_dbl = 0;
        l_rel = 0; n_rep = 0; n_press = 0; n_rel = 0;
    endtask

    // Drive one edge's inputs (called at negedge), then check after the edge
    task automatic step(input logic lvl, input logic en_v);
        int rel;
        level = lvl;
        en    = en_v;
        @(posedge clk);
        edge_no++;
        model_edge(lvl, en_v);
        @(negedge clk);
        chk_val("outs", {25'b0, outs}, m_exp);
        rel = edge_no - base_edge;
        if (press_pulse)   begin n_press++; if (f_press == 0) f_press = rel; end
        if (short_press  && f_short == 0) f_short = rel;
        if (long_press   && f_long  == 0) f_long  = rel;
        if (double_click && f_dbl   == 0) f_dbl   = rel;
        if (release_pulse) begin n_rel++; l_rel = rel; end
        if (repeat_pulse)  n_rep++;
    endtask

    // Level is high on relative edges [r1,f1) and [r2,f2); en drops from eoff
    task automatic run_seq(input int r1, input int f1, input int r2, input int f2,
                           input int n, input int eoff);
        clear_stats();
        for (int e = 1; e <= n; e++) begin
            step(((e >= r1 && e < f1) || (e >= r2 && e < f2)),
                 !(eoff != 0 && e >= eoff));
        end
    endtask

    // Asynchronous reset between edges; outputs must clear immediately
    task automatic async_reset(input logic lvl);
        level = lvl;
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async_rst", {25'b0, outs}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic lvl_r;
        int   len;
        logic en_r;

        @(negedge clk);
        async_reset(1'b0);

        // Short press
        run_seq(10, 13, 0, 0, 25, 0);
        chk_val("sp_press", f_press, 10);
        chk_val("sp_rel",   l_rel,   13);
        chk_val("sp_short", f_short, 18);
        chk_val("sp_long",  f_long,  0);
        chk_val("sp_dbl",   f_dbl,   0);

        // Double click
        run_seq(10, 13, 16, 18, 30, 0);
        chk_val("dc_dbl",   f_dbl,   16);
        chk_val("dc_npr",   n_press, 2);
        chk_val("dc_rel",   l_rel,   18);
        chk_val("dc_short", f_short, 0);

        // Long hold with repeat; fall at 30 beats the repeat due there
        run_seq(10, 30, 0, 0, 40, 0);
        chk_val("lh_long",  f_long,  18);
        chk_val("lh_nrep",  n_rep,   3);
        chk_val("lh_rel",   l_rel,   30);
        chk_val("lh_short", f_short, 0);

        // Boundary fall exactly at the long threshold
        run_seq(10, 18, 0, 0, 30, 0);
        chk_val("bf_long",  f_long,  0);
        chk_val("bf_rel",   l_rel,   18);
        chk_val("bf_short", f_short, 23);

        // Held through reset: release is silent, next rise is a normal press
        async_reset(1'b1);
        run_seq(0, 5, 8, 11, 25, 0);
        chk_val("hr_npr",   n_press, 1);
        chk_val("hr_press", f_press, 8);
        chk_val("hr_nrel",  n_rel,   1);
        chk_val("hr_short", f_short, 16);

        // Disable during the double-click window drops the pending short press
        run_seq(10, 13, 0, 0, 25, 15);
        chk_val("en_short", f_short, 0);
        run_seq(0, 0, 0, 0, 3, 0);

        // Async reset while long-held, then release with no pulses
        run_seq(5, 100, 0, 0, 20, 0);
        chk_val("ar_long", f_long, 13);
        async_reset(1'b1);
        run_seq(0, 3, 0, 0, 10, 0);
        chk_val("ar_npr", n_press, 0);
        chk_val("ar_nrel", n_rel, 0);

        // Randomized runs of level, occasional disable and async reset
        clear_stats();
        lvl_r = 1'b0;
        for (int k = 0; k < 300; k++) begin
            lvl_r = ~lvl_r;
            len   = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 25)
                                                : $urandom_range(1, 10);
            en_r  = ($urandom_range(0, 19) != 0);
            for (int j = 0; j < len; j++) step(lvl_r, en_r);
            if ($urandom_range(0, 59) == 0) async_reset(lvl_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
